mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I memory-access stage, directly downstream of the EX/MEM pipeline register.
//  - Consumes EX/MEM fields; drives the data-memory/cache port.
//  - Performs load/store byte-lane alignment and extension; detects misalignment.
//  - Stalls the pipeline until memory responds, then registers results into MEM/WB.
// PARAMETERS
//  XLEN        32  datapath/address width
//  MIN_ACC_CYC 2   minimum cycles per memory access (ISSUE + WAIT); fixed, not tunable
// PORTS
//  clk            in   1     clock, rising edge
//  reset          in   1     synchronous, active-high
//  mux_d_mem      in   1     EX/MEM: writeback select (1 = memory data, 0 = ALU result)
//  write_reg_en   in   1     EX/MEM: register-file write enable
//  write_address  in   5     EX/MEM: destination register
//  d_mem_r        in   1     EX/MEM: load
//  d_mem_w        in   1     EX/MEM: store
//  fun_3          in   3     EX/MEM: funct3 (size / signedness)
//  data_2         in   32    EX/MEM: store data (rs2)
//  alu_result     in   32    EX/MEM: effective address or ALU result
//  dmem_addr      out  32    word-aligned address ({alu_result[31:2],2'b00})
//  dmem_wdata     out  32    lane-replicated store data
//  dmem_byte_en   out  4     store byte enables
//  dmem_read      out  1     read request
//  dmem_write     out  1     write request
//  dmem_rdata     in   32    read data, valid when request high and dmem_busy low
//  dmem_busy      in   1     memory not ready
//  stall          out  1     freeze PC/IF/ID/EX and EX/MEM register
//  misalign_fault out  1     registered one-cycle pulse
//  wb_mux_sel     out  1     MEM/WB: writeback select
//  wb_reg_en      out  1     MEM/WB: register write enable
//  wb_address     out  5     MEM/WB: destination register
//  wb_mem_data    out  32    MEM/WB: extended load data
//  wb_alu_result  out  32    MEM/WB: ALU result
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including dmem_read/dmem_write (combinational, driven 0 in IDLE under reset).
//  - FSM states: IDLE, ISSUE, WAIT. Access = (d_mem_r | d_mem_w) & aligned & legal fun_3.
//  - IDLE, no access or faulting access: stall=0; MEM/WB captures inputs next edge (1-cycle pass-through).
//  - IDLE + access: stall=1; next state ISSUE.
//  - ISSUE: request asserted; stall=1; next state WAIT.
//  - WAIT: request asserted.
//    - dmem_busy=1: stall=1; stay in WAIT.
//    - dmem_busy=0: stall=0; capture dmem_rdata into MEM/WB; next state IDLE.
//  - Request (dmem_read/dmem_write) held high throughout ISSUE and WAIT; a store therefore completes exactly once.
//  - While stall=1, MEM/WB loads a bubble: wb_reg_en=0, other fields hold. No double writeback.
//  - Loads, lane = addr[1:0]:
//    - LB/LBU: sign/zero-extend byte at lane.
//    - LH/LHU: halfword at addr[1]*16.
//    - LW: full word.
//  - Stores:
//    - SB: wdata={4{b}}, byte_en=1<<addr[1:0].
//    - SH: wdata={2{h}}, byte_en=addr[1] ? 4'b1100 : 4'b0011.
//    - SW: byte_en=4'b1111.
//  - Fault cases (no request issued; misalign_fault=1 for one cycle; wb_reg_en=0 for that instruction):
//    - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
//    - Illegal funct3: load 3/6/7; store >=3.
//  - d_mem_r & d_mem_w both high: treated as illegal → fault.
//  - Reset in ISSUE/WAIT: immediate return to IDLE; requests drop on that edge; in-flight result discarded.
//  - Non-memory instructions with write_reg_en=1: wb_alu_result=alu_result; wb_mem_data=0.
// STRUCTURE
//  - Package riscv_mem_pkg: funct3 constants (F3_B/H/W/BU/HU), state enum, XLEN.
//  - Sub-module lsu_align: purely combinational lane formatting (store replicate/byte_en, load extract/extend, misalign check).
//  - mem_stage: FSM, stall, request drive, MEM/WB register.
// TESTING
//  1. LW addr=0x104, rdata=0xDEADBEEF, busy=0 → stall 2 cycles; wb_mem_data=0xDEADBEEF, wb_reg_en=1 once.
//  2. LB addr=0x103, rdata=0x80FF_0000 → wb_mem_data=0xFFFFFF80; LBU → 0x00000080.
//  3. SH addr=0x102, data_2=0x1234ABCD → wdata=0xABCDABCD, byte_en=4'b1100, dmem_write high exactly ISSUE+WAIT.
//  4. LW addr=0x106 → no dmem_read, stall=0, misalign_fault pulse 1 cycle, wb_reg_en=0.
//  5. LW with dmem_busy high 5 cycles → stall 6 cycles; wb_reg_en=0 throughout, then 1 once.
//  6. Reset asserted in WAIT → next cycle state IDLE, dmem_read=0, stall=0, all wb_* = 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I memory-access stage.
// Provides the datapath width, the funct3 load/store size codes and the
// memory-stage FSM state type.
package riscv_mem_pkg;

   localparam int XLEN        = 32;
   localparam int MIN_ACC_CYC = 2;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane formatting for loads and stores.
// Ports:
//   d_mem_r, d_mem_w  load / store strobes of the current instruction
//   fun_3             size / signedness
//   addr_lo           low two bits of the effective address
//   data_2            store data (rs2)
//   rdata             raw read word from memory
//   wdata, byte_en    lane-replicated store data and byte enables
//   load_data         extracted and extended load value
//   fault             memory op with an illegal funct3, both strobes, or misaligned
module lsu_align
   import riscv_mem_pkg::*;
(
   input  logic            d_mem_r,
   input  logic            d_mem_w,
   input  logic [2:0]      fun_3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] data_2,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] wdata,
   output logic [3:0]      byte_en,
   output logic [XLEN-1:0] load_data,
   output logic            fault
);

   logic [XLEN-1:0] byte_word;
   logic [XLEN-1:0] half_word;
   logic            illegal;
   logic            misaligned;

   always_comb begin
      byte_word = rdata >> {addr_lo, 3'b000};
      half_word = rdata >> {addr_lo[1], 4'b0000};

      load_data = '0;
      case (fun_3)
         F3_B:    load_data = {{24{byte_word[7]}}, byte_word[7:0]};
         F3_BU:   load_data = {24'd0, byte_word[7:0]};
         F3_H:    load_data = {{16{half_word[15]}}, half_word[15:0]};
         F3_HU:   load_data = {16'd0, half_word[15:0]};
         F3_W:    load_data = rdata;
         default: load_data = '0;
      endcase

      wdata   = data_2;
      byte_en = 4'b0000;
      case (fun_3)
         F3_B: begin
            wdata   = {4{data_2[7:0]}};
            byte_en = 4'b0001 << addr_lo;
         end
         F3_H: begin
            wdata   = {2{data_2[15:0]}};
            byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         F3_W: begin
            wdata   = data_2;
            byte_en = 4'b1111;
         end
         default: begin
            wdata   = data_2;
            byte_en = 4'b0000;
         end
      endcase

      // Both strobes at once has no defined meaning, so it faults too.
      illegal = 1'b0;
      if (d_mem_r && d_mem_w)
         illegal = 1'b1;
      else if (d_mem_r)
         illegal = (fun_3 == 3'd3) || (fun_3 == 3'd6) || (fun_3 == 3'd7);
      else if (d_mem_w)
         illegal = (fun_3 >= 3'd3);

      // fun_3[1:0] encodes size for all legal codes (00 byte, 01 half, 10 word).
      misaligned = 1'b0;
      case (fun_3[1:0])
         2'b01:   misaligned = addr_lo[0];
         2'b10:   misaligned = (addr_lo != 2'b00);
         default: misaligned = 1'b0;
      endcase

      fault = (d_mem_r || d_mem_w) && (illegal || misaligned);
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage between the EX/MEM and MEM/WB pipeline registers.
// Inputs:  EX/MEM fields (mux_d_mem, write_reg_en, write_address, d_mem_r,
//          d_mem_w, fun_3, data_2, alu_result), memory response (dmem_rdata,
//          dmem_busy), clk, synchronous active-high reset.
// Outputs: data-memory request (dmem_addr, dmem_wdata, dmem_byte_en,
//          dmem_read, dmem_write), pipeline stall, misalign_fault pulse and
//          the MEM/WB register (wb_mux_sel, wb_reg_en, wb_address,
//          wb_mem_data, wb_alu_result).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no access in flight; non-memory and faulting ops pass through
// ST_ISSUE | first request cycle, pipeline frozen
// ST_WAIT  | request held until dmem_busy drops, then result is captured
module mem_stage
   import riscv_mem_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            mux_d_mem,
   input  logic            write_reg_en,
   input  logic [4:0]      write_address,
   input  logic            d_mem_r,
   input  logic            d_mem_w,
   input  logic [2:0]      fun_3,
   input  logic [XLEN-1:0] data_2,
   input  logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_byte_en,
   output logic            dmem_read,
   output logic            dmem_write,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_busy,
   output logic            stall,
   output logic            misalign_fault,
   output logic            wb_mux_sel,
   output logic            wb_reg_en,
   output logic [4:0]      wb_address,
   output logic [XLEN-1:0] wb_mem_data,
   output logic [XLEN-1:0] wb_alu_result
);

   mem_state_e      state_q, state_d;
   logic            fault_q, fault_d;
   logic            mux_sel_q, mux_sel_d;
   logic            reg_en_q, reg_en_d;
   logic [4:0]      address_q, address_d;
   logic [XLEN-1:0] mem_data_q, mem_data_d;
   logic [XLEN-1:0] alu_q, alu_d;

   logic [XLEN-1:0] fmt_wdata;
   logic [3:0]      fmt_byte_en;
   logic [XLEN-1:0] load_data;
   logic            op_fault;
   logic            access;
   logic            req;
   logic            stall_raw;

   lsu_align u_align (
      .d_mem_r   (d_mem_r),
      .d_mem_w   (d_mem_w),
      .fun_3     (fun_3),
      .addr_lo   (alu_result[1:0]),
      .data_2    (data_2),
      .rdata     (dmem_rdata),
      .wdata     (fmt_wdata),
      .byte_en   (fmt_byte_en),
      .load_data (load_data),
      .fault     (op_fault)
   );

   assign access = (d_mem_r || d_mem_w) && !op_fault;

   always_comb begin
      state_d    = state_q;
      stall_raw  = 1'b0;
      req        = 1'b0;
      fault_d    = 1'b0;
      mux_sel_d  = mux_sel_q;
      reg_en_d   = 1'b0;     // bubble unless an instruction retires this cycle
      address_d  = address_q;
      mem_data_d = mem_data_q;
      alu_d      = alu_q;

      case (state_q)
         ST_IDLE: begin
            if (access) begin
               stall_raw = 1'b1;
               state_d   = ST_ISSUE;
            end else begin
               fault_d    = op_fault;
               mux_sel_d  = mux_d_mem;
               reg_en_d   = write_reg_en && !op_fault;
               address_d  = write_address;
               mem_data_d = '0;
               alu_d      = alu_result;
            end
         end
         ST_ISSUE: begin
            req       = 1'b1;
            stall_raw = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            req = 1'b1;
            if (dmem_busy) begin
               stall_raw = 1'b1;
            end else begin
               mux_sel_d  = mux_d_mem;
               reg_en_d   = write_reg_en;
               address_d  = write_address;
               mem_data_d = d_mem_r ? load_data : '0;
               alu_d      = alu_result;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fault_q    <= 1'b0;
         mux_sel_q  <= 1'b0;
         reg_en_q   <= 1'b0;
         address_q  <= '0;
         mem_data_q <= '0;
         alu_q      <= '0;
      end else begin
         state_q    <= state_d;
         fault_q    <= fault_d;
         mux_sel_q  <= mux_sel_d;
         reg_en_q   <= reg_en_d;
         address_q  <= address_d;
         mem_data_q <= mem_data_d;
         alu_q      <= alu_d;
      end
   end

   // Requests follow the registered state so they drop on the reset edge;
   // stall is additionally masked so a held pipeline is released under reset.
   assign stall        = stall_raw && !reset;
   assign dmem_read    = req && d_mem_r;
   assign dmem_write   = req && d_mem_w;
   assign dmem_addr    = req ? {alu_result[XLEN-1:2], 2'b00} : '0;
   assign dmem_wdata   = dmem_write ? fmt_wdata : '0;
   assign dmem_byte_en = dmem_write ? fmt_byte_en : 4'b0000;

   assign misalign_fault = fault_q;
   assign wb_mux_sel     = mux_sel_q;
   assign wb_reg_en      = reg_en_q;
   assign wb_address     = address_q;
   assign wb_mem_data    = mem_data_q;
   assign wb_alu_result  = alu_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mux_d_mem, write_reg_en, d_mem_r, d_mem_w;
   logic [4:0]  write_address;
   logic [2:0]  fun_3;
   logic [31:0] data_2, alu_result, dmem_rdata;
   logic        dmem_busy;
   logic [31:0] dmem_addr, dmem_wdata, wb_mem_data, wb_alu_result;
   logic [3:0]  dmem_byte_en;
   logic        dmem_read, dmem_write, stall, misalign_fault;
   logic        wb_mux_sel, wb_reg_en;
   logic [4:0]  wb_address;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset(reset),
      .mux_d_mem(mux_d_mem), .write_reg_en(write_reg_en), .write_address(write_address),
      .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .fun_3(fun_3),
      .data_2(data_2), .alu_result(alu_result),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
      .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy),
      .stall(stall), .misalign_fault(misalign_fault),
      .wb_mux_sel(wb_mux_sel), .wb_reg_en(wb_reg_en), .wb_address(wb_address),
      .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result)
   );

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_fault(input logic r, input logic w, input logic [2:0] f3,
                                      input logic [31:0] addr);
      bit legal;
      if (!r && !w) return 0;
      if (r && w) return 1;
      if (r) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      else   legal = (f3 <= 2);
      if (!legal) return 1;
      return (addr % op_size(f3)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      longint unsigned v;
      int lane;
      lane = int'(addr % 4);
      v = longint'(rdata) / (longint'(1) << (8 * lane));
      case (f3)
         3'd0: begin v = v % 256;   return (v >= 128)   ? 32'(v - 256)   : 32'(v); end
         3'd4: return 32'(v % 256);
         3'd1: begin v = v % 65536; return (v >= 32768) ? 32'(v - 65536) : 32'(v); end
         3'd5: return 32'(v % 65536);
         default: return rdata;
      endcase
   endfunction

   function automatic logic [35:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] data);
      logic [7:0]  bytes [4];
      logic [31:0] wd;
      logic [3:0]  be;
      int lane, sz;
      lane = int'(addr % 4);
      sz = op_size(f3);
      be = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         bytes[k] = 8'((data >> (8 * (k % sz))) & 32'hFF);
         if (k >= lane && k < lane + sz) be[k] = 1'b1;
      end
      wd = {bytes[3], bytes[2], bytes[1], bytes[0]};
      return {be, wd};
   endfunction

   // ---------------- stimulus driver / observer ----------------
   task automatic drive_nop();
      mux_d_mem = 0; write_reg_en = 0; write_address = 0; d_mem_r = 0; d_mem_w = 0;
      fun_3 = 0; data_2 = 0; alu_result = 0; dmem_busy = 0;
   endtask

   task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int n_busy, input logic issue_busy,
                         output int stall_c, output int req_c, output int wben_c,
                         output int fault_c, output logic [31:0] wbdata,
                         output logic [31:0] wdata, output logic [3:0] be,
                         output logic [31:0] maddr, output bit timed_out);
      int waits;
      bit done;
      stall_c = 0; req_c = 0; wben_c = 0; fault_c = 0; wbdata = 0; wdata = 0;
      be = 0; maddr = 0; timed_out = 1; waits = 0;
      @(negedge clk);
      mux_d_mem = r; write_reg_en = r; write_address = 5'($urandom_range(1, 31));
      d_mem_r = r; d_mem_w = w; fun_3 = f3; alu_result = addr; data_2 = data;
      dmem_rdata = rdata;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         if (dmem_read || dmem_write) begin
            req_c++;
            if (req_c == 1) dmem_busy = issue_busy;
            else begin
               dmem_busy = (waits < n_busy);
               if (waits < n_busy) waits++;
            end
         end else dmem_busy = 0;
         #1;
         if (stall) stall_c++;
         if (dmem_read || dmem_write) begin
            wdata = dmem_wdata; be = dmem_byte_en; maddr = dmem_addr;
         end
         done = !stall;
         @(posedge clk); #1;
         if (wb_reg_en) begin wben_c++; wbdata = wb_mem_data; end
         if (misalign_fault) fault_c++;
         if (done) begin timed_out = 0; break; end
      end
      @(negedge clk);
      drive_nop();
      @(posedge clk); #1;
      if (wb_reg_en) wben_c++;
      if (misalign_fault) fault_c++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_nop();
      dmem_rdata = 32'hFFFF_FFFF;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({dmem_read, dmem_write, stall, misalign_fault, wb_reg_en, wb_mux_sel} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got=%b want=000000",
                  {dmem_read, dmem_write, stall, misalign_fault, wb_reg_en, wb_mux_sel});
      end
      tests_run++;
      if ({wb_address, wb_mem_data, wb_alu_result, dmem_addr, dmem_byte_en} !== 105'b0) begin
         tests_failed++;
         $display("FAIL reset_data got addr=%h mem=%h alu=%h daddr=%h be=%b want all 0",
                  wb_address, wb_mem_data, wb_alu_result, dmem_addr, dmem_byte_en);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_lw_basic();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      run_op(1, 0, 3'd2, 32'h104, 0, 32'hDEADBEEF, 0, 0, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || s != 2 || q != 2 || e != 1 || f != 0) begin
         tests_failed++;
         $display("FAIL lw_basic_timing got to=%0d stall=%0d req=%0d wben=%0d flt=%0d want 0/2/2/1/0",
                  to, s, q, e, f);
      end
      tests_run++;
      if (wb !== 32'hDEADBEEF || ma !== 32'h104) begin
         tests_failed++;
         $display("FAIL lw_basic_data got data=%h addr=%h want deadbeef/00000104", wb, ma);
      end
   endtask

   task automatic test_lb_lbu();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      run_op(1, 0, 3'd0, 32'h103, 0, 32'h80FF_0000, 0, 0, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || e != 1 || wb !== 32'hFFFFFF80 || ma !== 32'h100) begin
         tests_failed++;
         $display("FAIL lb_sign got to=%0d wben=%0d data=%h addr=%h want 0/1/ffffff80/00000100",
                  to, e, wb, ma);
      end
      run_op(1, 0, 3'd4, 32'h103, 0, 32'h80FF_0000, 0, 0, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || e != 1 || wb !== 32'h00000080) begin
         tests_failed++;
         $display("FAIL lbu_zero got to=%0d wben=%0d data=%h want 0/1/00000080", to, e, wb);
      end
   endtask

   task automatic test_sh();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      run_op(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 0, 0, 0, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || wd !== 32'hABCDABCD || be !== 4'b1100 || q != 2 || s != 2 || e != 0) begin
         tests_failed++;
         $display("FAIL sh_store got to=%0d wdata=%h be=%b req=%0d stall=%0d wben=%0d want 0/abcdabcd/1100/2/2/0",
                  to, wd, be, q, s, e);
      end
   endtask

   task automatic test_misaligned_lw();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      run_op(1, 0, 3'd2, 32'h106, 0, 32'h11111111, 0, 0, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || q != 0 || s != 0 || f != 1 || e != 0) begin
         tests_failed++;
         $display("FAIL lw_misalign got to=%0d req=%0d stall=%0d flt=%0d wben=%0d want 0/0/0/1/0",
                  to, q, s, f, e);
      end
   endtask

   task automatic test_busy_wait();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      // busy high in ISSUE plus four WAIT cycles: five busy cycles in total
      run_op(1, 0, 3'd2, 32'h200, 0, 32'hCAFEF00D, 4, 1, s, q, e, f, wb, wd, be, ma, to);
      tests_run++;
      if (to || s != 6 || q != 6 || e != 1 || wb !== 32'hCAFEF00D) begin
         tests_failed++;
         $display("FAIL busy_wait got to=%0d stall=%0d req=%0d wben=%0d data=%h want 0/6/6/1/cafef00d",
                  to, s, q, e, wb);
      end
   endtask

   task automatic test_random_access();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      logic [2:0] f3; logic [31:0] addr, data, rdata; logic [35:0] st; logic r;
      int nb, errs;
      logic [2:0] ld_f3 [5];
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         r = 1'($urandom_range(0, 1));
         f3 = r ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         addr = $urandom & ~(32'(op_size(f3)) - 1);
         data = $urandom; rdata = $urandom; nb = $urandom_range(0, 3);
         run_op(r, !r, f3, addr, data, rdata, nb, 1'($urandom_range(0, 1)),
                s, q, e, f, wb, wd, be, ma, to);
         st = model_store(f3, addr, data);
         tests_run++;
         if (to || s != 2 + nb || q != 2 + nb || f != 0 || e != (r ? 1 : 0) ||
             ma !== {addr[31:2], 2'b00} ||
             (r && wb !== model_load(f3, addr, rdata)) ||
             (!r && {be, wd} !== st)) begin
            tests_failed++;
            errs++;
            if (errs < 5)
               $display("FAIL rand_access r=%0d f3=%0d addr=%h got stall=%0d req=%0d wben=%0d flt=%0d wb=%h be=%b wd=%h want stall=%0d wb=%h be=%b wd=%h",
                        r, f3, addr, s, q, e, f, wb, be, wd, 2 + nb,
                        model_load(f3, addr, rdata), st[35:32], st[31:0]);
         end
      end
   endtask

   task automatic test_random_faults();
      int s, q, e, f; logic [31:0] wb, wd, ma; logic [3:0] be; bit to;
      logic [2:0] f3; logic [31:0] addr; logic r, w; int errs;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         do begin
            r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7)); addr = $urandom;
         end while (!model_fault(r, w, f3, addr));
         run_op(r, w, f3, addr, $urandom, $urandom, 0, 0, s, q, e, f, wb, wd, be, ma, to);
         tests_run++;
         if (to || q != 0 || s != 0 || f != 1 || e != 0) begin
            tests_failed++;
            errs++;
            if (errs < 5)
               $display("FAIL rand_fault r=%0d w=%0d f3=%0d addr=%h got req=%0d stall=%0d flt=%0d wben=%0d want 0/0/1/0",
                        r, w, f3, addr, q, s, f, e);
         end
      end
   endtask

   task automatic test_passthrough();
      logic [31:0] a; logic en, ms; logic [4:0] rd; int errs;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive_nop();
         a = $urandom; en = 1'($urandom_range(0, 1)); ms = 1'($urandom_range(0, 1));
         rd = 5'($urandom);
         alu_result = a; write_reg_en = en; mux_d_mem = ms; write_address = rd;
         fun_3 = 3'($urandom); data_2 = $urandom;
         #1;
         tests_run++;
         if (stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL pass_nostall got stall=%b rd=%b wr=%b want 0/0/0", stall, dmem_read, dmem_write);
         end
         @(posedge clk); #1;
         tests_run++;
         if (wb_alu_result !== a || wb_reg_en !== en || wb_address !== rd ||
             wb_mux_sel !== ms || wb_mem_data !== 32'd0 || misalign_fault !== 1'b0) begin
            tests_failed++;
            errs++;
            if (errs < 5)
               $display("FAIL pass_wb got alu=%h en=%b rd=%0d ms=%b mem=%h flt=%b want alu=%h en=%b rd=%0d ms=%b mem=0 flt=0",
                        wb_alu_result, wb_reg_en, wb_address, wb_mux_sel, wb_mem_data,
                        misalign_fault, a, en, rd, ms);
         end
      end
      @(negedge clk);
      drive_nop();
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      mux_d_mem = 1; write_reg_en = 1; write_address = 5'd7; d_mem_r = 1; d_mem_w = 0;
      fun_3 = 3'd2; alu_result = 32'h300; dmem_rdata = 32'h5555AAAA; dmem_busy = 1;
      repeat (2) @(negedge clk);   // now in WAIT
      #1;
      tests_run++;
      if (dmem_read !== 1'b1 || stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_wait_pre got rd=%b stall=%b want 1/1", dmem_read, stall);
      end
      reset = 1;
      @(posedge clk); #1;
      tests_run++;
      if (dmem_read !== 1'b0 || stall !== 1'b0 || wb_reg_en !== 1'b0 || wb_mux_sel !== 1'b0 ||
          wb_address !== 5'd0 || wb_mem_data !== 32'd0 || wb_alu_result !== 32'd0) begin
         tests_failed++;
         $display("FAIL rst_wait got rd=%b stall=%b en=%b ms=%b rd=%0d mem=%h alu=%h want all 0",
                  dmem_read, stall, wb_reg_en, wb_mux_sel, wb_address, wb_mem_data, wb_alu_result);
      end
      @(negedge clk);
      reset = 0;
      drive_nop();
      @(posedge clk); #1;
      tests_run++;
      if (dmem_read !== 1'b0 || wb_reg_en !== 1'b0 || wb_mem_data !== 32'd0) begin
         tests_failed++;
         $display("FAIL rst_wait_after got rd=%b en=%b mem=%h want 0/0/0", dmem_read, wb_reg_en, wb_mem_data);
      end
   endtask

   initial begin
      drive_nop();
      dmem_rdata = 0;
      reset = 1;
      test_reset();
      test_lw_basic();
      test_lb_lbu();
      test_sh();
      test_misaligned_lw();
      test_busy_wait();
      test_passthrough();
      test_random_access();
      test_random_faults();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
